// File: rtl/conv3x3_pkg.sv
// Shared constants and arithmetic helpers for the 3x3 streaming convolution accelerator.
// The bus register map, CFG/STATUS field positions and the accumulator type live here.
package conv3x3_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ACC_W      = 2 * DATA_W_DEF + 4;

  localparam int ADDR_PIXEL   = 0;
  localparam int ADDR_RESULT  = 1;
  localparam int ADDR_CTRL    = 2;
  localparam int ADDR_WEIGHT0 = 3;
  localparam int ADDR_WEIGHT8 = 11;
  localparam int ADDR_CFG     = 12;
  localparam int ADDR_STATUS  = 13;
  localparam int ADDR_POS     = 14;

  localparam int CFG_W_LSB     = 0;
  localparam int CFG_H_LSB     = 8;
  localparam int CFG_SHIFT_LSB = 16;
  localparam int CFG_RELU_BIT  = 24;

  localparam int ST_CNT_LSB   = 0;
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_FDONE_BIT = 11;
  localparam int ST_UDF_BIT   = 12;

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t relu(input acc_t v, input logic en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  // Clamps v into the signed range of a dw-bit result.
  function automatic acc_t saturate(input acc_t v, input int unsigned dw);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (dw - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv3x3_stream_acc_fifo.sv
// Result FIFO: synchronous, power-of-two depth, with occupancy count and a synchronous clear.
// A pop while full makes room for a push on the same edge.
module acc_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o && !clr_i;
  assign push_ok = push_i && (!full_o || pop_i) && !clr_i;

  // NOTE: storage carries no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv3x3_stream_acc.sv
// Memory-mapped 3x3 convolution accelerator: one pixel per bus write, one result per pixel,
// results drained from a FIFO through the RESULT register.
module conv3x3_stream_acc
  import conv3x3_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int LB_D  = 2 * MAX_W + 3;
  localparam int LB_AW = $clog2(LB_D);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic signed [DATA_W-1:0] weight_q [9];
  logic signed [DATA_W-1:0] lb_q [LB_D];
  logic [7:0]  cfg_w_q, cfg_h_q;
  logic [4:0]  shift_q;
  logic        relu_q;
  logic [7:0]  col_q, row_q, col_d, row_d;
  logic        v_q, v_last_q;
  logic [7:0]  v_col_q, v_row_q;
  logic        ovf_q, fdone_q, udf_q;
  logic [DATA_W-1:0] dout_q, rd_data;

  // Bus decode
  logic wr, rd, wr_pixel, wr_ctrl, wr_cfg, wr_status, wr_weight, rd_result, soft_clr;
  logic [ADDR_W-1:0] w_idx;
  assign wr        = en && we;
  assign rd        = en && !we;
  assign wr_pixel  = wr && (addr == ADDR_W'(ADDR_PIXEL));
  assign wr_ctrl   = wr && (addr == ADDR_W'(ADDR_CTRL));
  assign wr_cfg    = wr && (addr == ADDR_W'(ADDR_CFG));
  assign wr_status = wr && (addr == ADDR_W'(ADDR_STATUS));
  assign wr_weight = wr && (addr >= ADDR_W'(ADDR_WEIGHT0)) && (addr <= ADDR_W'(ADDR_WEIGHT8));
  assign rd_result = rd && (addr == ADDR_W'(ADDR_RESULT));
  assign w_idx     = addr - ADDR_W'(ADDR_WEIGHT0);
  assign soft_clr  = (wr_ctrl && din[0]) || wr_cfg;

  logic [7:0] eff_w, eff_h;
  logic       last_col, last_row;
  always_comb begin
    eff_w = cfg_w_q;
    if (cfg_w_q == 8'd0)             eff_w = 8'd1;
    else if (cfg_w_q > 8'(MAX_W))    eff_w = 8'(MAX_W);
    eff_h = (cfg_h_q == 8'd0) ? 8'd1 : cfg_h_q;
  end
  assign last_col = (col_q >= eff_w - 8'd1);
  assign last_row = (row_q >= eff_h - 8'd1);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (soft_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (wr_pixel) begin
      col_d = last_col ? 8'd0 : col_q + 8'd1;
      if (last_col) row_d = last_row ? 8'd0 : row_q + 8'd1;
    end
  end

  // Window gather with zero padding, using the position captured with the pixel.
  logic signed [DATA_W-1:0] tap [9];
  logic [LB_AW-1:0] t_w, t_2w;
  logic r1, r2, c1, c2;
  always_comb begin
    t_w  = LB_AW'(eff_w);
    t_2w = LB_AW'(2 * eff_w);
    r1   = (v_row_q >= 8'd1);
    r2   = (v_row_q >= 8'd2);
    c1   = (v_col_q >= 8'd1);
    c2   = (v_col_q >= 8'd2);
    tap[8] = lb_q[0];
    tap[7] = c1 ? lb_q[1] : '0;
    tap[6] = c2 ? lb_q[2] : '0;
    tap[5] = r1 ? lb_q[t_w] : '0;
    tap[4] = (r1 && c1) ? lb_q[t_w + LB_AW'(1)] : '0;
    tap[3] = (r1 && c2) ? lb_q[t_w + LB_AW'(2)] : '0;
    tap[2] = r2 ? lb_q[t_2w] : '0;
    tap[1] = (r2 && c1) ? lb_q[t_2w + LB_AW'(1)] : '0;
    tap[0] = (r2 && c2) ? lb_q[t_2w + LB_AW'(2)] : '0;
  end

  acc_t acc, acc_post;
  logic [DATA_W-1:0] mac_res;
  // NOTE: blocking '=' is correct here; the running sum must be visible to the next term.
  always_comb begin
    acc = '0;
    for (int k = 0; k < 9; k++) acc = acc + acc_t'(tap[k]) * acc_t'(weight_q[k]);
    acc_post = saturate(relu(acc >>> shift_q, relu_q), DATA_W);
    mac_res  = DATA_W'(acc_post);
  end

  logic                 fifo_push, fifo_full, fifo_empty;
  logic [DATA_W-1:0]    fifo_rdata;
  logic [CNT_W-1:0]     fifo_count;
  assign fifo_push = v_q && !soft_clr;

  acc_result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (soft_clr),
    .push_i  (fifo_push),
    .wdata_i (mac_res),
    .pop_i   (rd_result),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) weight_q[k] <= '0;
      cfg_w_q <= 8'(MAX_W);
      cfg_h_q <= 8'(MAX_W);
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 9; k++)
        if (wr_weight && (w_idx == ADDR_W'(k))) weight_q[k] <= din;
      if (wr_cfg) begin
        cfg_w_q <= din[CFG_W_LSB +: 8];
        cfg_h_q <= din[CFG_H_LSB +: 8];
        shift_q <= din[CFG_SHIFT_LSB +: 5];
        relu_q  <= din[CFG_RELU_BIT];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LB_D; i++) lb_q[i] <= '0;
    end else if (soft_clr) begin
      for (int i = 0; i < LB_D; i++) lb_q[i] <= '0;
    end else if (wr_pixel) begin
      lb_q[0] <= din;
      for (int i = 1; i < LB_D; i++) lb_q[i] <= lb_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      v_q      <= 1'b0;
      v_col_q  <= '0;
      v_row_q  <= '0;
      v_last_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v_q   <= wr_pixel && !soft_clr;
      if (wr_pixel) begin
        v_col_q  <= col_q;
        v_row_q  <= row_q;
        v_last_q <= last_col && last_row;
      end
    end
  end

  // Sticky flags: a same-edge set wins over a W1C write.
  logic [2:0] w1c;
  assign w1c = wr_status ? din[ST_UDF_BIT:ST_OVF_BIT] : 3'b000;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      fdone_q <= 1'b0;
      udf_q   <= 1'b0;
    end else if (soft_clr) begin
      ovf_q   <= 1'b0;
      fdone_q <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      ovf_q   <= (fifo_push && fifo_full && !rd_result) || (ovf_q && !w1c[0]);
      fdone_q <= (fifo_push && v_last_q) || (fdone_q && !w1c[1]);
      udf_q   <= (rd_result && fifo_empty) || (udf_q && !w1c[2]);
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd) begin
      if (addr == ADDR_W'(ADDR_RESULT)) begin
        rd_data = fifo_empty ? '0 : fifo_rdata;
      end else if (addr == ADDR_W'(ADDR_CFG)) begin
        rd_data[CFG_W_LSB +: 8]     = cfg_w_q;
        rd_data[CFG_H_LSB +: 8]     = cfg_h_q;
        rd_data[CFG_SHIFT_LSB +: 5] = shift_q;
        rd_data[CFG_RELU_BIT]       = relu_q;
      end else if (addr == ADDR_W'(ADDR_STATUS)) begin
        rd_data[ST_CNT_LSB +: CNT_W] = fifo_count;
        rd_data[ST_EMPTY_BIT]        = fifo_empty;
        rd_data[ST_FULL_BIT]         = fifo_full;
        rd_data[ST_OVF_BIT]          = ovf_q;
        rd_data[ST_FDONE_BIT]        = fdone_q;
        rd_data[ST_UDF_BIT]          = udf_q;
      end else if (addr == ADDR_W'(ADDR_POS)) begin
        rd_data[7:0]  = col_q;
        rd_data[15:8] = row_q;
      end else begin
        for (int k = 0; k < 9; k++)
          if ((addr >= ADDR_W'(ADDR_WEIGHT0)) && (w_idx == ADDR_W'(k))) rd_data = weight_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= rd_data;
  end
  assign dout = dout_q;

endmodule
